// File: rtl/sum_sq_window.sv
// Windowed sum of squares over WIN = 2^WIN_LOG2 signed samples, feeding a
// downstream square-root stage. Two stages: square, then accumulate/saturate.
module sum_sq_window #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 4,
  parameter int OUT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic signed [DATA_W-1:0]   s_data,
  input  logic                       clear,
  output logic        [OUT_W-1:0]    n_out,
  output logic                       n_valid,
  output logic                       n_sat,
  output logic        [WIN_LOG2-1:0] win_idx
);

  // Handshake: a sample is taken on every rising edge with s_valid=1 and
  // clear=0; there is no backpressure. n_valid is a one-cycle strobe and
  // n_out/n_sat are held between strobes.

  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = SQ_W + WIN_LOG2;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [WIN_LOG2-1:0] LAST_IDX = '1;

  logic [WIN_LOG2-1:0] win_idx_q, win_idx_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_last_q, s1_last_d;
  logic [SQ_W-1:0]     s1_sq_q, s1_sq_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0]    n_out_q, n_out_d;
  logic                n_valid_q, n_valid_d;
  logic                n_sat_q, n_sat_d;

  logic                    accept;
  logic signed [SQ_W-1:0]  s_ext;
  logic signed [SQ_W-1:0]  sq_signed;
  logic [ACC_W-1:0]        sum;
  logic [EXT_W-1:0]        sum_ext;
  logic [EXT_W-1:0]        max_ext;
  logic                    over;

  assign accept = s_valid & ~clear;

  // Sign-extend before multiplying; the product of two DATA_W signed values
  // always fits in SQ_W bits as a non-negative number, so it reads as unsigned.
  assign s_ext     = SQ_W'(s_data);
  assign sq_signed = s_ext * s_ext;

  assign sum     = acc_q + ACC_W'(s1_sq_q);
  assign sum_ext = EXT_W'(sum);
  assign max_ext = EXT_W'({OUT_W{1'b1}});
  assign over    = (sum_ext > max_ext);

  // Stage 1: window position and squared sample.
  always_comb begin
    win_idx_d  = win_idx_q;
    s1_valid_d = 1'b0;
    s1_last_d  = 1'b0;
    s1_sq_d    = s1_sq_q;
    if (clear) begin
      win_idx_d = '0;
    end else if (accept) begin
      win_idx_d  = win_idx_q + WIN_LOG2'(1);
      s1_valid_d = 1'b1;
      s1_last_d  = (win_idx_q == LAST_IDX);
      s1_sq_d    = $unsigned(sq_signed);
    end
  end

  // Stage 2: accumulate; on the last entry publish and restart the window.
  always_comb begin
    acc_d     = acc_q;
    n_out_d   = n_out_q;
    n_sat_d   = n_sat_q;
    n_valid_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (s1_valid_q) begin
      if (s1_last_q) begin
        acc_d     = '0;
        n_valid_d = 1'b1;
        n_sat_d   = over;
        n_out_d   = over ? {OUT_W{1'b1}} : sum_ext[OUT_W-1:0];
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_idx_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sq_q    <= '0;
      acc_q      <= '0;
      n_out_q    <= '0;
      n_valid_q  <= 1'b0;
      n_sat_q    <= 1'b0;
    end else begin
      win_idx_q  <= win_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_sq_q    <= s1_sq_d;
      acc_q      <= acc_d;
      n_out_q    <= n_out_d;
      n_valid_q  <= n_valid_d;
      n_sat_q    <= n_sat_d;
    end
  end

  assign n_out   = n_out_q;
  assign n_valid = n_valid_q;
  assign n_sat   = n_sat_q;
  assign win_idx = win_idx_q;

endmodule

// File: tb/tb_sum_sq_window.sv
// Randomized and directed bench for sum_sq_window against a window-level
// reference model (sum of squares per completed window, one edge of delay).
module tb_sum_sq_window;

  localparam int DATA_W   = 8;
  localparam int WIN_LOG2 = 4;
  localparam int OUT_W    = 16;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int MAXV     = (1 << OUT_W) - 1;

  logic                      clk;
  logic                      rst_n;
  logic                      s_valid;
  logic signed [DATA_W-1:0]  s_data;
  logic                      clear;
  logic        [OUT_W-1:0]   n_out;
  logic                      n_valid;
  logic                      n_sat;
  logic        [WIN_LOG2-1:0] win_idx;

  sum_sq_window #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .clear(clear), .n_out(n_out), .n_valid(n_valid), .n_sat(n_sat),
    .win_idx(win_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int  cnt, wsum, pend_sum, exp_nout, step_no;
  bit  pend, exp_sat, strobe;
  logic [OUT_W-1:0] exp_q[$];
  bit               sat_q[$];

  // observation
  int pulse_cnt, last_val, last_step, s16_step, first_pulse_step;
  bit last_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt = 0; wsum = 0; pend = 0; pend_sum = 0;
    exp_nout = 0; exp_sat = 0;
    exp_q.delete(); sat_q.delete();
  endtask

  // driver: present inputs, take one edge, update model, check outputs
  task automatic step(input bit v, input int d, input bit c);
    logic [OUT_W-1:0] e;
    bit es;
    s_valid = v;
    s_data  = DATA_W'(d);
    clear   = c;
    @(posedge clk);
    #1;
    step_no++;
    strobe = 0;
    if (c) begin
      pend = 0; cnt = 0; wsum = 0;
    end else begin
      if (pend) begin
        strobe   = 1;
        exp_sat  = (pend_sum > MAXV);
        exp_nout = exp_sat ? MAXV : pend_sum;
        exp_q.push_back(OUT_W'(exp_nout));
        sat_q.push_back(exp_sat);
        pend = 0;
      end
      if (v) begin
        wsum += d * d;
        cnt++;
        if (cnt == WIN) begin
          pend = 1; pend_sum = wsum; cnt = 0; wsum = 0;
        end
      end
    end
    check("n_valid", n_valid, strobe);
    check("win_idx", win_idx, cnt);
    check("n_out_held", n_out, exp_nout);
    check("n_sat_held", n_sat, exp_sat);
    if (n_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", n_valid, 0);
      end else begin
        e  = exp_q.pop_front();
        es = sat_q.pop_front();
        check("pulse_n_out", n_out, e);
        check("pulse_n_sat", n_sat, es);
      end
      if (pulse_cnt == 0) first_pulse_step = step_no;
      pulse_cnt++;
      last_val  = n_out;
      last_sat  = n_sat;
      last_step = step_no;
    end
    s_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic feed(input int n, input int d);
    for (int i = 0; i < n; i++) step(1, d, 0);
    s16_step = step_no;
  endtask

  initial begin
    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; clear = 1'b0;
    step_no = 0; pulse_cnt = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_n_out", n_out, 0);
    check("rst_n_valid", n_valid, 0);
    check("rst_n_sat", n_sat, 0);
    check("rst_win_idx", win_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic window
    pulse_cnt = 0;
    feed(16, 3);
    idle(3);
    check("basic_pulses", pulse_cnt, 1);
    check("basic_n_out", last_val, 144);
    check("basic_sat", last_sat, 0);
    check("basic_latency", last_step - s16_step, 1);

    // saturation
    pulse_cnt = 0;
    feed(16, -128);
    idle(3);
    check("sat_pulses", pulse_cnt, 1);
    check("sat_n_out", last_val, 65535);
    check("sat_flag", last_sat, 1);

    // gapped input
    pulse_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 3));
      step(1, 5, 0);
    end
    idle(4);
    check("gap_pulses", pulse_cnt, 1);
    check("gap_n_out", last_val, 400);

    // back-to-back windows
    pulse_cnt = 0;
    feed(32, 2);
    idle(3);
    check("b2b_pulses", pulse_cnt, 2);
    check("b2b_spacing", last_step - first_pulse_step, 16);
    check("b2b_n_out", last_val, 64);

    // clear mid-window
    pulse_cnt = 0;
    feed(5, 7);
    step(0, 0, 1);
    feed(16, 1);
    idle(3);
    check("clr_pulses", pulse_cnt, 1);
    check("clr_n_out", last_val, 16);

    // clear coincident with the 16th sample
    pulse_cnt = 0;
    feed(15, 1);
    step(1, 1, 1);
    idle(3);
    check("clr16_pulses", pulse_cnt, 0);

    // clear while the last entry is in stage 1
    pulse_cnt = 0;
    feed(16, 6);
    step(0, 0, 1);
    idle(3);
    check("clrpend_pulses", pulse_cnt, 0);

    // reset mid-window
    feed(9, 4);
    rst_n = 1'b0;
    #1;
    check("mrst_n_out", n_out, 0);
    check("mrst_n_valid", n_valid, 0);
    check("mrst_n_sat", n_sat, 0);
    check("mrst_win_idx", win_idx, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    pulse_cnt = 0;
    feed(16, -1);
    idle(3);
    check("mrst_pulses", pulse_cnt, 1);
    check("mrst_result", last_val, 16);
    check("mrst_idx_end", win_idx, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? -128 : $signed($urandom_range(0, 255)) - 128,
           $urandom_range(0, 99) == 0);
    end
    idle(3);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
